alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer that shares the single 4-bit combinational ALU (add/sub/and/or) between two requesters. It accepts one operation at a time over a valid/ready handshake, drives the shared ALU operand and opcode inputs from registered copies, captures the ALU result, and returns it to the originating requester over a response handshake. It sits between the requester blocks and the ALU instance; the ALU itself stays combinational and is unchanged.

## Interface
- Parameters: none. Width fixed at 4 bits, matching the ALU.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: arbiter accepts requester 0 this cycle.
- `req0_a`, `req0_b` in 4 each: requester 0 operands.
- `req0_op` in 2: requester 0 opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `rsp0_valid` out 1: result for requester 0 available.
- `rsp0_ready` in 1: requester 0 takes the result.
- `rsp0_result` out 4: result for requester 0.
- `rsp1_valid`, `rsp1_ready`, `rsp1_result`: same as response 0, for requester 1.
- `alu_a`, `alu_b` out 4 each: to the shared ALU operands.
- `alu_op` out 2: to the ALU select input.
- `alu_result` in 4: from the ALU, combinational.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Opcode encoding: 00 add (A+B mod 16), 01 sub (A−B mod 16, two's complement), 10 AND, 11 OR.
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant logic is combinational: `reqN_ready` = (state==IDLE) && grant==N.
  - At most one `ready` is high in a cycle.
  - On valid&&ready, latch a/b/op into operand registers, record the owner, and go to EXEC.
  - With no valid request, stay in IDLE.
- **EXEC**
  - `alu_*` show the latched operands.
  - Capture `alu_result` into the result register at the clock edge, then go to RESP.
- **RESP**
  - `rspN_valid` is high only for the owner.
  - `rspN_result` = result register.
  - Hold until the owner's `rsp_ready` is high at a clock edge, then go to IDLE.
- `alu_a`, `alu_b`, `alu_op` always reflect the operand registers, including in IDLE and RESP.
- Requesters must hold valid and payload stable until ready. The arbiter does not sample payload on cycles without a handshake.
- A new request is never accepted while in EXEC or RESP. Both `ready` outputs are low.
- The non-owner's `rsp_ready` is ignored.
- Only one response is in flight at a time.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state=IDLE.
  - Operand registers, result register and `alu_*` = 0.
  - All `rsp*_valid` = 0, `busy` = 0.
  - last_grant=1, so requester 0 wins first.
- Reset in EXEC or RESP: the in-flight operation is discarded with no response. The requester must re-issue.
- Latency:
  - Handshake at edge T.
  - EXEC during cycle T..T+1.
  - `rsp_valid` is high from edge T+1 onward; the result is visible in the cycle after EXEC, which is 2 cycles after the request cycle.
- Minimum spacing between accepts is 3 cycles, with `rsp_ready` tied high.
- Response hold: the result stays stable while `rsp_valid`=1 and `rsp_ready`=0.
- Simultaneous valid from both requesters: the grant follows the policy in Configuration. last_grant updates only on an accepted handshake.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. When both requesters are valid, grant goes to the one not equal to last_grant. When only one is valid, it is granted.
- Not defined: fixed priority. Requester 0 always wins when valid, and requester 1 is granted only when `req0_valid`=0. last_grant is still kept, but it is unused.

## Test plan
- **Basic add:** after reset, req0 a=3 b=5 op=00 for one accepted cycle, `rsp0_ready`=1.
  - Expect `req0_ready`=1 in the request cycle.
  - `rsp0_valid`=1 with `rsp0_result`=8 two cycles later for exactly one cycle.
  - `busy` high for 2 cycles.
- **Sub wrap and logic ops:** req1 a=2 b=5 op=01 → `rsp1_result`=4'hD. Then a=4'hC b=4'hA op=10 → 4'h8. Then op=11 → 4'hE. `rsp0_valid` stays 0 throughout.
- **Contention:** both valid from reset and held, both `rsp_ready`=1.
  - Expect req0 first.
  - With `ALU_ARB_RR_EN`, accepts alternate 0,1,0,1.
  - Without it, every accept is req0 until `req0_valid` drops, then req1.
- **Backpressure:** after req0 a=7 b=1 op=00, hold `rsp0_ready`=0 for 4 cycles while req1 is valid.
  - `rsp0_result`=8 held stable.
  - `req1_ready`=0 throughout.
  - req1 is accepted in the cycle after `rsp0_ready` goes high.
- **Reset mid-operation:** assert `rst_n`=0 during EXEC.
  - Next cycle: `busy`=0, `rsp*_valid`=0, `alu_a`=`alu_b`=0, `alu_op`=0.
  - No response is ever produced for the dropped request.
- **Stability:** req0 valid with a/b/op changing on non-handshake cycles (`ready` low). The captured result reflects only the payload at the handshake edge.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 4-bit ALU (add/sub/and/or) between
// two requesters. A request is accepted over a valid/ready handshake, its
// operands are registered and driven to the ALU, and the captured result is
// returned to the requester that issued it over a response handshake.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise requester 0 has fixed priority.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [1:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [1:0] req1_op,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [3:0] rsp0_result,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [3:0] rsp1_result,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_result,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] opa_q;
    logic [3:0] opb_q;
    logic [1:0] op_q;
    logic [3:0] result_q;
    logic       owner_q;
    logic       last_grant_q;

    logic       grant;
    logic       accept;
    logic       owner_rsp_ready;

    // Pick which requester would be served if the arbiter is idle.
    always_comb begin
        grant = 1'b0;
`ifdef ALU_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
`else
        grant = ~req0_valid & req1_valid;
`endif
    end

    // Handshake qualification and the owner's response acceptance.
    always_comb begin
        req0_ready      = (state == IDLE) && !grant;
        req1_ready      = (state == IDLE) && grant;
        accept          = grant ? (req1_valid && req1_ready)
                                : (req0_valid && req0_ready);
        owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: accept -> execute for one cycle -> hold response.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on handshake, result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= '0;
            result_q     <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            if (accept) begin
                opa_q        <= grant ? req1_a  : req0_a;
                opb_q        <= grant ? req1_b  : req0_b;
                op_q         <= grant ? req1_op : req0_op;
                owner_q      <= grant;
                last_grant_q <= grant;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
            end
        end
    end

    // ALU inputs always mirror the operand registers; responses go to the owner only.
    always_comb begin
        alu_a       = opa_q;
        alu_b       = opb_q;
        alu_op      = op_q;
        rsp0_valid  = (state == RESP) && !owner_q;
        rsp1_valid  = (state == RESP) && owner_q;
        rsp0_result = result_q;
        rsp1_result = result_q;
        busy        = (state != IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the
// shared ALU port. Expected values are hand-computed constants.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic [1:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic [1:0] req1_op;
    logic       rsp0_valid, rsp0_ready;
    logic [3:0] rsp0_result;
    logic       rsp1_valid, rsp1_ready;
    logic [3:0] rsp1_result;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_result;
    logic       busy;

    int checks;
    int failures;

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .busy        (busy)
    );

    // Shared combinational ALU.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = alu_a & alu_b;
            2'b11: alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for a handshake, returns the accepted requester and
    // the number of idle cycles waited; leaves the bench 1ns after the
    // accepting edge, i.e. inside the EXEC cycle.
    task automatic wait_accept(output int who, output int waited);
        who    = -1;
        waited = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (req0_valid && req0_ready) begin
                who = 0;
                break;
            end
            if (req1_valid && req1_ready) begin
                who = 1;
                break;
            end
            cyc();
            waited++;
        end
        if (who < 0) begin
            check("accept_timeout", 32'd1, 32'd0);
        end else begin
            cyc();
        end
    endtask

    // One full transaction on a given port with rsp_ready high.
    task automatic run_op(input int port, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op, input logic [3:0] exp, input string tag);
        int who, waited;
        if (port == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        wait_accept(who, waited);
        check({tag, "_owner"}, who, port);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
        if (port == 0) begin
            check({tag, "_rsp0_valid"}, rsp0_valid, 1'b1);
            check({tag, "_rsp0_result"}, rsp0_result, exp);
            check({tag, "_rsp1_valid"}, rsp1_valid, 1'b0);
        end else begin
            check({tag, "_rsp1_valid"}, rsp1_valid, 1'b1);
            check({tag, "_rsp1_result"}, rsp1_result, exp);
            check({tag, "_rsp0_valid"}, rsp0_valid, 1'b0);
        end
        cyc();
    endtask

    int exp_seq [5];
    int who;
    int waited;

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
`ifdef ALU_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1, 1};
`else
        exp_seq = '{0, 0, 0, 0, 1};
`endif

        // Reset state
        do_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_alu_a", alu_a, 4'd0);
        check("rst_alu_b", alu_b, 4'd0);
        check("rst_alu_op", alu_op, 2'd0);

        // Basic add with exact cycle timing
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5; req0_op = 2'b00;
        #1;
        check("add_req0_ready", req0_ready, 1'b1);
        check("add_req1_ready", req1_ready, 1'b0);
        cyc();
        req0_valid = 1'b0;
        check("add_exec_busy", busy, 1'b1);
        check("add_exec_rsp0_valid", rsp0_valid, 1'b0);
        check("add_exec_alu_a", alu_a, 4'd3);
        check("add_exec_alu_b", alu_b, 4'd5);
        check("add_exec_req0_ready", req0_ready, 1'b0);
        cyc();
        check("add_resp_rsp0_valid", rsp0_valid, 1'b1);
        check("add_resp_result", rsp0_result, 4'd8);
        check("add_resp_busy", busy, 1'b1);
        check("add_resp_rsp1_valid", rsp1_valid, 1'b0);
        cyc();
        check("add_done_rsp0_valid", rsp0_valid, 1'b0);
        check("add_done_busy", busy, 1'b0);

        // Sub wrap and logic ops on requester 1
        run_op(1, 4'd2, 4'd5, 2'b01, 4'hD, "sub");
        run_op(1, 4'hC, 4'hA, 2'b10, 4'h8, "and");
        run_op(1, 4'hC, 4'hA, 2'b11, 4'hE, "or");

        // Contention from reset
        do_reset();
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_op = 2'b00;
        req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd3; req1_op = 2'b01;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req0_valid = 1'b0;
            wait_accept(who, waited);
            check($sformatf("cont_owner%0d", k), who, exp_seq[k]);
            if (k > 0 && k < 4) check($sformatf("cont_spacing%0d", k), waited, 2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
        check("cont_last_rsp1_result", rsp1_result, 4'd6);
        cyc();

        // Backpressure on response 0 while requester 1 waits
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd1; req0_op = 2'b00;
        wait_accept(who, waited);
        check("bp_owner", who, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_op = 2'b00;
        cyc();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_rsp0_valid%0d", k), rsp0_valid, 1'b1);
            check($sformatf("bp_rsp0_result%0d", k), rsp0_result, 4'd8);
            check($sformatf("bp_req1_ready%0d", k), req1_ready, 1'b0);
            cyc();
        end
        rsp0_ready = 1'b1;
        #1;
        check("bp_release_req1_ready", req1_ready, 1'b0);
        cyc();
        check("bp_idle_rsp0_valid", rsp0_valid, 1'b0);
        check("bp_idle_req1_ready", req1_ready, 1'b1);
        cyc();
        req1_valid = 1'b0;
        cyc();
        check("bp_rsp1_valid", rsp1_valid, 1'b1);
        check("bp_rsp1_result", rsp1_result, 4'd4);
        cyc();

        // Reset during EXEC
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd6; req0_op = 2'b11;
        wait_accept(who, waited);
        check("mid_owner", who, 0);
        check("mid_busy_exec", busy, 1'b1);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("mid_busy", busy, 1'b0);
        check("mid_rsp0_valid", rsp0_valid, 1'b0);
        check("mid_rsp1_valid", rsp1_valid, 1'b0);
        check("mid_alu_a", alu_a, 4'd0);
        check("mid_alu_b", alu_b, 4'd0);
        check("mid_alu_op", alu_op, 2'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("mid_no_rsp%0d", k), rsp0_valid | rsp1_valid, 1'b0);
        end

        // Payload stability: req0 changes payload while blocked
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_op = 2'b00;
        wait_accept(who, waited);
        check("stab_owner1", who, 1);
        req1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1;
            req0_a = 4'(k * 5 + 3);
            req0_b = 4'(15 - k);
            req0_op = 2'(k + 1);
            #1;
            check($sformatf("stab_req0_ready%0d", k), req0_ready, 1'b0);
            cyc();
        end
        check("stab_rsp1_result", rsp1_result, 4'd2);
        req0_a = 4'd4; req0_b = 4'd9; req0_op = 2'b00;
        rsp1_ready = 1'b1;
        cyc();
        wait_accept(who, waited);
        check("stab_owner0", who, 0);
        check("stab_waited", waited, 0);
        req0_valid = 1'b0;
        req0_a = 4'hF; req0_b = 4'hF; req0_op = 2'b11;
        check("stab_alu_a", alu_a, 4'd4);
        check("stab_alu_b", alu_b, 4'd9);
        cyc();
        check("stab_rsp0_valid", rsp0_valid, 1'b1);
        check("stab_rsp0_result", rsp0_result, 4'hD);
        cyc();
        check("stab_done_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
